// File: rtl/fetch_pkg.sv
// Shared definitions for the parametrised fetch stage.
//   redir_e        : redirect request encodings (seq / branch / jump / reserved)
//   fetch_state_e  : fetch controller states
//   *_MSB / *_LSB  : MIPS R/I/J field bit positions within an instruction word
//   HALT_WORD_DEFAULT : default instruction encoding that stops fetch
package fetch_pkg;

  typedef enum logic [1:0] {
    REDIR_SEQ  = 2'b00,
    REDIR_BR   = 2'b01,
    REDIR_J    = 2'b10,
    REDIR_RSVD = 2'b11
  } redir_e;

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StHalt  = 2'b10,
    StFault = 2'b11
  } fetch_state_e;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/inst_rom.sv
// Word-addressed instruction ROM with an asynchronous read port.
// Kept in its own module so it can be swapped for a block RAM later.
//   addr_i  : word address (IMEM_AW bits), depth 2**IMEM_AW
//   rdata_o : 32-bit word at addr_i, combinational
// Contents are written into mem by the surrounding environment.
module inst_rom #(
  parameter int unsigned IMEM_AW   = 6,
  parameter string       IMEM_FILE = "inst.coe.hex"
) (
  input  logic [IMEM_AW-1:0] addr_i,
  output logic [31:0]        rdata_o
);

  logic [31:0] mem [2**IMEM_AW];

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/fetch_unit_param.sv
// Parametrised instruction-fetch stage.
// Holds the PC, reads the instruction ROM combinationally, slices MIPS fields
// and registers one selected byte onto the board LEDs.
//   clk, rst (sync, active low)       : clock and reset
//   stall, redir, br_off, j_index     : PC advance control
//   MUX                               : LED source, 0-3 Inst_code bytes, 4-7 PC bytes
//   PC, Inst_code, op_code..imm       : fetch address, fetched word and its fields
//   inst_valid, halted, fault         : fetch status
//   LED                               : registered selected byte
// Optional: define FETCH_PERF_CNT_EN to add fetch_cnt/stall_cnt outputs; MUX 4-7
// then select fetch_cnt bytes instead of PC bytes.
module fetch_unit_param
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     IMEM_AW   = 6,
  parameter logic [PC_W-1:0] INIT_PC   = '0,
  parameter string           IMEM_FILE = "inst.coe.hex",
  parameter logic [31:0]     HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      redir,
  input  logic [15:0]     br_off,
  input  logic [25:0]     j_index,
  input  logic [2:0]      MUX,
  output logic [PC_W-1:0] PC,
  output logic [31:0]     Inst_code,
  output logic [5:0]      op_code,
  output logic [4:0]      rs_addr,
  output logic [4:0]      rt_addr,
  output logic [4:0]      rd_addr,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic            inst_valid,
  output logic            halted,
  output logic            fault,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic [7:0]      LED
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      led_q, led_d;
  logic [PC_W-1:0] pc4, br_ext, br_pc, j_pc, next_pc;
  logic [27:0]     j_tgt;
  logic [31:0]     hi_word, led_src;
  logic            bad_pc;

  inst_rom #(
    .IMEM_AW  (IMEM_AW),
    .IMEM_FILE(IMEM_FILE)
  ) u_rom (
    .addr_i (pc_q[IMEM_AW+1:2]),
    .rdata_o(Inst_code)
  );

  assign op_code = Inst_code[OP_MSB:OP_LSB];
  assign rs_addr = Inst_code[RS_MSB:RS_LSB];
  assign rt_addr = Inst_code[RT_MSB:RT_LSB];
  assign rd_addr = Inst_code[RD_MSB:RD_LSB];
  assign shamt   = Inst_code[SHAMT_MSB:SHAMT_LSB];
  assign funct   = Inst_code[FUNCT_MSB:FUNCT_LSB];
  assign imm     = Inst_code[IMM_MSB:IMM_LSB];

  // All PC arithmetic wraps at PC_W bits.
  assign pc4    = pc_q + PC_W'(4);
  assign br_ext = PC_W'($signed(br_off));
  assign br_pc  = pc4 + (br_ext << 2);
  assign j_tgt  = {j_index, 2'b00};

  if (PC_W > 28) begin : g_j_wide
    assign j_pc = {pc4[PC_W-1:28], j_tgt};
  end else begin : g_j_narrow
    assign j_pc = j_tgt[PC_W-1:0];
  end

  always_comb begin
    case (redir_e'(redir))
      REDIR_BR: next_pc = br_pc;
      REDIR_J:  next_pc = j_pc;
      default:  next_pc = pc4;
    endcase
  end

  // Anything above the ROM word range is a fault; no silent wrap into the ROM.
  assign bad_pc = (pc_q[1:0] != 2'b00) || ((pc_q >> (IMEM_AW + 2)) != '0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (bad_pc) begin
          state_d = StFault;
        end else if (Inst_code == HALT_WORD) begin
          state_d = StHalt;
        end else if (!stall) begin
          pc_d = next_pc;
        end
      end
      default: ;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        advance;

  assign advance = (state_q == StRun) && !bad_pc && (Inst_code != HALT_WORD) && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (advance) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q == StRun) && stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign hi_word   = fetch_cnt_q;
`else
  assign hi_word   = 32'(pc_q);
`endif

  always_comb begin
    led_src = MUX[2] ? hi_word : Inst_code;
    led_d   = led_src[{MUX[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StBoot;
      pc_q    <= INIT_PC;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      led_q   <= led_d;
    end
  end

  assign PC         = pc_q;
  assign LED        = led_q;
  assign inst_valid = (state_q == StRun);
  assign halted     = (state_q == StHalt);
  assign fault      = (state_q == StFault);

endmodule

// File: tb/tb_fetch_unit_param.sv
// Bench for fetch_unit_param: three instances (ROM 16 words, ROM 64 words, and
// 64 words with a misaligned reset PC) share one stimulus stream and are each
// compared every cycle against a behavioural model. Directed steps pin known
// values, then randomized stimulus runs over a random ROM image.
module tb_fetch_unit_param;

  localparam int NDUT = 3;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic [1:0]  redir;
  logic [15:0] br_off;
  logic [25:0] j_index;
  logic [2:0]  MUX;

  logic [31:0] pc_o    [NDUT];
  logic [31:0] inst_o  [NDUT];
  logic [5:0]  op_o    [NDUT];
  logic [4:0]  rs_o    [NDUT];
  logic [4:0]  rt_o    [NDUT];
  logic [4:0]  rd_o    [NDUT];
  logic [4:0]  sh_o    [NDUT];
  logic [5:0]  fn_o    [NDUT];
  logic [15:0] imm_o   [NDUT];
  logic        valid_o [NDUT];
  logic        halt_o  [NDUT];
  logic        fault_o [NDUT];
  logic [7:0]  led_o   [NDUT];
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_o  [NDUT];
  logic [31:0] scnt_o  [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fetch_unit_param #(
      .PC_W     (32),
      .IMEM_AW  ((g == 0) ? 4 : 6),
      .INIT_PC  ((g == 2) ? 32'h2 : 32'h0),
      .IMEM_FILE(""),
      .HALT_WORD(32'hFFFF_FFFF)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .redir     (redir),
      .br_off    (br_off),
      .j_index   (j_index),
      .MUX       (MUX),
      .PC        (pc_o[g]),
      .Inst_code (inst_o[g]),
      .op_code   (op_o[g]),
      .rs_addr   (rs_o[g]),
      .rt_addr   (rt_o[g]),
      .rd_addr   (rd_o[g]),
      .shamt     (sh_o[g]),
      .funct     (fn_o[g]),
      .imm       (imm_o[g]),
      .inst_valid(valid_o[g]),
      .halted    (halt_o[g]),
      .fault     (fault_o[g]),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt (fcnt_o[g]),
      .stall_cnt (scnt_o[g]),
`endif
      .LED       (led_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam logic [1:0] M_BOOT = 2'd0, M_RUN = 2'd1, M_HALT = 2'd2, M_FAULT = 2'd3;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] pc;
    logic [7:0]  led;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } mdl_t;

  logic [31:0] img [64];
  mdl_t        mdl [NDUT];
  bit          chk_en;
  int          n_checks;
  int          n_pass;

  function automatic int aw_of(input int g);
    return (g == 0) ? 4 : 6;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc, input int aw);
    int idx;
    idx = int'((pc >> 2) % (32'd1 << aw));
    return img[idx];
  endfunction

  function automatic mdl_t step(input mdl_t m, input int g, input logic r, input logic st,
                                input logic [1:0] rd, input logic [15:0] bo,
                                input logic [25:0] ji, input logic [2:0] mx);
    mdl_t        n;
    logic [31:0] inst, src, pc4;
    int          aw;
    aw = aw_of(g);
    n  = m;
    if (!r) begin
      n.mode = M_BOOT;
      n.pc   = (g == 2) ? 32'h2 : 32'h0;
      n.led  = 8'h00;
      n.fcnt = 0;
      n.scnt = 0;
      return n;
    end
    inst  = word_at(m.pc, aw);
    src   = (mx >= 3'd4) ? (PERF ? m.fcnt : m.pc) : inst;
    n.led = 8'((src >> (8 * (mx % 4))) & 32'hFF);
    if (m.mode == M_BOOT) begin
      n.mode = M_RUN;
    end else if (m.mode == M_RUN) begin
      if (st) n.scnt = m.scnt + 1;
      if ((m.pc % 4 != 0) || (m.pc >= (32'd4 << aw))) begin
        n.mode = M_FAULT;
      end else if (inst == 32'hFFFF_FFFF) begin
        n.mode = M_HALT;
      end else if (!st) begin
        pc4 = m.pc + 4;
        if (rd == 2'd1)      n.pc = pc4 + 32'($signed(bo)) * 4;
        else if (rd == 2'd2) n.pc = (pc4 & 32'hF000_0000) | (32'(ji) * 4);
        else                 n.pc = pc4;
        n.fcnt = m.fcnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      mdl[g] <= step(mdl[g], g, rst, stall, redir, br_off, j_index, MUX);
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h (t=%0t)", name, g, act, exp, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] ei;
    if (chk_en) begin
      for (int g = 0; g < NDUT; g++) begin
        ei = word_at(mdl[g].pc, aw_of(g));
        chk("pc",     g, pc_o[g],           mdl[g].pc);
        chk("inst",   g, inst_o[g],         ei);
        chk("op",     g, 32'(op_o[g]),      ei >> 26);
        chk("rs",     g, 32'(rs_o[g]),      (ei >> 21) & 32'h1F);
        chk("rt",     g, 32'(rt_o[g]),      (ei >> 16) & 32'h1F);
        chk("rd",     g, 32'(rd_o[g]),      (ei >> 11) & 32'h1F);
        chk("shamt",  g, 32'(sh_o[g]),      (ei >> 6) & 32'h1F);
        chk("funct",  g, 32'(fn_o[g]),      ei & 32'h3F);
        chk("imm",    g, 32'(imm_o[g]),     ei & 32'hFFFF);
        chk("valid",  g, 32'(valid_o[g]),   32'(mdl[g].mode == M_RUN));
        chk("halted", g, 32'(halt_o[g]),    32'(mdl[g].mode == M_HALT));
        chk("fault",  g, 32'(fault_o[g]),   32'(mdl[g].mode == M_FAULT));
        chk("led",    g, 32'(led_o[g]),     32'(mdl[g].led));
`ifdef FETCH_PERF_CNT_EN
        chk("fcnt",   g, fcnt_o[g],         mdl[g].fcnt);
        chk("scnt",   g, scnt_o[g],         mdl[g].scnt);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 16; i++) g_dut[0].u_dut.u_rom.mem[i] = img[i];
    for (int i = 0; i < 64; i++) begin
      g_dut[1].u_dut.u_rom.mem[i] = img[i];
      g_dut[2].u_dut.u_rom.mem[i] = img[i];
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    chk_en   = 1'b0;
    rst      = 1'b0;
    stall    = 1'b0;
    redir    = 2'b00;
    br_off   = '0;
    j_index  = '0;
    MUX      = 3'd0;

    for (int i = 0; i < 64; i++) img[i] = 32'h0000_0000;
    img[0]  = 32'h2001_0005;
    img[1]  = 32'h2002_0003;
    img[2]  = 32'h0022_1820;
    img[3]  = 32'hFFFF_FFFF;
    img[16] = 32'h1234_5678;
    load_rom();

    tick();
    tick();
    chk_en = 1'b1;
    chk("lit_rst_valid", 1, 32'(valid_o[1]), 32'd0);
    chk("lit_rst_led",   1, 32'(led_o[1]),   32'd0);

    // Boot, then sequential fetch.
    rst = 1'b1;
    tick();
    chk("lit_pc0",  1, pc_o[1],          32'h0);
    chk("lit_op0",  1, 32'(op_o[1]),     32'h08);
    chk("lit_mdl0", 1, mdl[1].pc,        32'h0);
    tick();
    chk("lit_pc4",  1, pc_o[1],          32'h4);

    // Stall for three cycles at PC=4.
    stall = 1'b1;
    repeat (3) begin
      tick();
      chk("lit_stall_pc",    1, pc_o[1],          32'h4);
      chk("lit_stall_valid", 1, 32'(valid_o[1]),  32'd1);
    end
    stall = 1'b0;
    tick();
    chk("lit_pc8",    1, pc_o[1],      32'h8);
    chk("lit_rs",     1, 32'(rs_o[1]), 32'd1);
    chk("lit_rt",     1, 32'(rt_o[1]), 32'd2);
    chk("lit_rd",     1, 32'(rd_o[1]), 32'd3);
    chk("lit_funct",  1, 32'(fn_o[1]), 32'h20);
    chk("lit_misalg", 2, 32'(fault_o[2]), 32'd1);

    // LED shows PC byte 0 while holding at PC=8.
    stall = 1'b1;
    MUX   = 3'd4;
    tick();
`ifndef FETCH_PERF_CNT_EN
    chk("lit_led_pc", 1, 32'(led_o[1]), 32'h08);
`endif

    // Backward branch 8 -> 4, then jump to 0x40.
    stall  = 1'b0;
    MUX    = 3'd0;
    redir  = 2'b01;
    br_off = 16'hFFFE;
    tick();
    chk("lit_br_pc", 1, pc_o[1], 32'h4);
    redir   = 2'b10;
    j_index = 26'h10;
    tick();
    chk("lit_j_pc6",    1, pc_o[1],          32'h40);
    chk("lit_j_pc4",    0, pc_o[0],          32'h40);
    redir = 2'b00;
    stall = 1'b1;
    tick();
    chk("lit_j_fault4", 0, 32'(fault_o[0]),  32'd1);
    chk("lit_j_fault6", 1, 32'(fault_o[1]),  32'd0);
    chk("lit_j_inst6",  1, inst_o[1],        32'h1234_5678);

    // LED byte select, one cycle after each MUX change.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] want;
      want = 32'h1234_5678 >> (8 * k);
      MUX  = 3'(k);
      tick();
      chk("lit_led_byte", 1, 32'(led_o[1]), want & 32'hFF);
    end

    // Reset while stalled, with dut0 sitting in FAULT.
    rst = 1'b0;
    tick();
    chk("lit_rf_pc",    0, pc_o[0],         32'h0);
    chk("lit_rf_fault", 0, 32'(fault_o[0]), 32'd0);
    chk("lit_rf_led",   0, 32'(led_o[0]),   32'd0);
    chk("lit_rf_valid", 0, 32'(valid_o[0]), 32'd0);
    stall = 1'b0;
    MUX   = 3'd0;
    rst   = 1'b1;

    // Run into the halt word at 0xC.
    repeat (5) tick();
    chk("lit_halt",    1, 32'(halt_o[1]),  32'd1);
    chk("lit_halt_pc", 1, pc_o[1],         32'hC);
    chk("lit_halt_v",  1, 32'(valid_o[1]), 32'd0);
    tick();
    chk("lit_halt_frz", 1, pc_o[1], 32'hC);
    rst = 1'b0;
    tick();
    chk("lit_hr_pc",   1, pc_o[1],        32'h0);
    chk("lit_hr_halt", 1, 32'(halt_o[1]), 32'd0);

    // Randomized phase over a random image with sparse halt words.
    for (int i = 0; i < 64; i++) begin
      img[i] = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
    end
    load_rom();
    tick();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 39) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      redir   = 2'($urandom_range(0, 3));
      br_off  = 16'($urandom_range(0, 40)) - 16'd20;
      j_index = 26'($urandom_range(0, 40));
      MUX     = 3'($urandom_range(0, 7));
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
